platform_led_pwm: RTL and testbench



---
 rtl/platform_led_pwm_pkg.sv | 19 +
 rtl/platform_led_pwm_blink_timer.sv | 40 ++++
 rtl/platform_led_pwm.sv | 112 +++++++++++
 tb/tb_platform_led_pwm.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/platform_led_pwm_pkg.sv
// Shared constants for the platform LED PWM controller: register word
// addresses and the BRIGHT reset pattern.
// Optional feature macro: PLATFORM_LED_PWM_SETCLR_EN (enables the SET/CLR aliases).
package platform_led_pkg;

    // Register word addresses on the Avalon-MM slave
    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_MODE   = 3'd1;
    localparam logic [2:0] ADDR_BRIGHT = 3'd2;
    localparam logic [2:0] ADDR_PERIOD = 3'd3;
    localparam logic [2:0] ADDR_SET    = 3'd4;
    localparam logic [2:0] ADDR_CLR    = 3'd5;

    // Widest supported brightness; the top slices the low PWM_BITS so a
    // freshly reset board comes up at full brightness.
    localparam int unsigned PWM_BITS_MAX = 16;
    localparam logic [PWM_BITS_MAX-1:0] BRIGHT_RST = '1;

endpackage

// File: rtl/platform_led_pwm_blink_timer.sv
// Blink half-period timer. Counts 0..period-1 and toggles phase on the
// last count. A zero period parks the timer with phase high (steady on),
// and a period write restarts the half-period with phase high so the new
// rate starts from a clean, visible "on" half.
module led_blink_timer #(
    parameter int BLINK_BITS = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BLINK_BITS-1:0] period,
    input  logic                  period_wr,
    output logic                  phase
);

    logic [BLINK_BITS-1:0] blink_cnt;
    logic [BLINK_BITS-1:0] period_last;
    logic                  period_zero;
    logic                  cnt_last;

    assign period_last = period - BLINK_BITS'(1);
    assign period_zero = (period == '0);
    assign cnt_last    = (blink_cnt == period_last);

    // Half-period counter and phase toggle; a period write wins over counting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (period_wr || period_zero) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (cnt_last) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + BLINK_BITS'(1);
        end
    end

endmodule

// File: rtl/platform_led_pwm.sv
// Avalon-MM LED controller: per-LED enable, per-LED blink, global PWM
// brightness and programmable blink half-period. out_port drives the
// board LEDs directly and is registered.
// Optional feature macro: PLATFORM_LED_PWM_SETCLR_EN adds write-1-to-set
// (address 4) and write-1-to-clear (address 5) aliases of DATA.
module platform_led_pwm
    import platform_led_pkg::*;
#(
    parameter int NUM_LEDS   = 10,
    parameter int PWM_BITS   = 8,
    parameter int BLINK_BITS = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    output logic [NUM_LEDS-1:0] out_port
);

    logic [NUM_LEDS-1:0]   data_reg;
    logic [NUM_LEDS-1:0]   mode_reg;
    logic [PWM_BITS-1:0]   bright_reg;
    logic [BLINK_BITS-1:0] period_reg;

    logic [PWM_BITS-1:0]   pwm_cnt;
    logic                  pwm_on;
    logic                  blink_phase;
    logic                  wr_en;
    logic                  period_wr;

    // Bits of writedata above each register's width are dropped by design
    logic                  unused_wdata;
    assign unused_wdata = ^writedata;

    assign wr_en     = chipselect & ~write_n;
    assign period_wr = wr_en && (address == ADDR_PERIOD);

    // Register file writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_reg   <= '0;
            mode_reg   <= '0;
            bright_reg <= BRIGHT_RST[PWM_BITS-1:0];
            period_reg <= '0;
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:   data_reg   <= writedata[NUM_LEDS-1:0];
                ADDR_MODE:   mode_reg   <= writedata[NUM_LEDS-1:0];
                ADDR_BRIGHT: bright_reg <= writedata[PWM_BITS-1:0];
                ADDR_PERIOD: period_reg <= writedata[BLINK_BITS-1:0];
`ifdef PLATFORM_LED_PWM_SETCLR_EN
                ADDR_SET:    data_reg   <= data_reg | writedata[NUM_LEDS-1:0];
                ADDR_CLR:    data_reg   <= data_reg & ~writedata[NUM_LEDS-1:0];
`endif
                default: ;
            endcase
        end
    end

    // Zero-wait-state read mux; reads do not need chipselect
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata[NUM_LEDS-1:0]   = data_reg;
            ADDR_MODE:   readdata[NUM_LEDS-1:0]   = mode_reg;
            ADDR_BRIGHT: readdata[PWM_BITS-1:0]   = bright_reg;
            ADDR_PERIOD: readdata[BLINK_BITS-1:0] = period_reg;
`ifdef PLATFORM_LED_PWM_SETCLR_EN
            ADDR_SET:    readdata[NUM_LEDS-1:0]   = data_reg;
            ADDR_CLR:    readdata[NUM_LEDS-1:0]   = data_reg;
`endif
            default:     readdata = '0;
        endcase
    end

    // Free-running PWM counter, wraps naturally at 2^PWM_BITS
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    // All-ones brightness is forced fully on rather than (2^N-1)/2^N
    assign pwm_on = (pwm_cnt < bright_reg) | (&bright_reg);

    led_blink_timer #(
        .BLINK_BITS (BLINK_BITS)
    ) u_blink_timer (
        .clk       (clk),
        .reset     (reset),
        .period    (period_reg),
        .period_wr (period_wr),
        .phase     (blink_phase)
    );

    // Registered LED drive: enable, PWM gate, and blink gate for blinking LEDs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_port <= '0;
        end else begin
            out_port <= data_reg
                      & {NUM_LEDS{pwm_on}}
                      & (~mode_reg | {NUM_LEDS{blink_phase}});
        end
    end

endmodule

// File: tb/tb_platform_led_pwm.sv
// Directed bench for platform_led_pwm with default parameters.
module tb_platform_led_pwm;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [9:0]  out_port;

    int n_cmp = 0;
    int n_bad = 0;

    platform_led_pwm dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  waddr;
        logic [31:0] wdata;
        logic [2:0]  raddr;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Single-cycle write; returns 1ns after the write edge
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int          ones;
        logic        found;
        logic [31:0] exp_set, exp_clr, exp_alias;

        vecs[0] = '{3'd0, 32'h0000_02A5, 3'd0, 32'h0000_02A5};
        vecs[1] = '{3'd0, 32'hFFFF_FFFF, 3'd0, 32'h0000_03FF};
        vecs[2] = '{3'd1, 32'hFFFF_F0F0, 3'd1, 32'h0000_00F0};
        vecs[3] = '{3'd2, 32'h0001_2345, 3'd2, 32'h0000_0045};
        vecs[4] = '{3'd3, 32'hAB12_3456, 3'd3, 32'h0012_3456};
        vecs[5] = '{3'd6, 32'hFFFF_FFFF, 3'd6, 32'h0000_0000};
        vecs[6] = '{3'd7, 32'h5555_5555, 3'd7, 32'h0000_0000};
        vecs[7] = '{3'd6, 32'h0000_0000, 3'd0, 32'h0000_03FF};

        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        cycles(3);
        @(negedge clk);
        reset = 1'b0;
        #1;

        // Reset values
        chk("rst_out", {22'h0, out_port}, 32'h0);
        rd(3'd0, r); chk("rst_data", r, 32'h0);
        rd(3'd1, r); chk("rst_mode", r, 32'h0);
        rd(3'd2, r); chk("rst_bright", r, 32'hFF);
        rd(3'd3, r); chk("rst_period", r, 32'h0);

        // Steady on, one-cycle latency to out_port
        wr(3'd0, 32'h0000_02A5);
        chk("steady_before", {22'h0, out_port}, 32'h0);
        cycles(1);
        chk("steady_after", {22'h0, out_port}, 32'h2A5);
        rd(3'd0, r); chk("steady_rdback", r, 32'h0000_02A5);

        // Asynchronous reset mid-run
        cycles(2);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_out", {22'h0, out_port}, 32'h0);
        rd(3'd0, r); chk("midrst_data", r, 32'h0);
        rd(3'd2, r); chk("midrst_bright", r, 32'hFF);
        @(negedge clk);
        reset = 1'b0;
        cycles(1);

        // Register write/readback table
        for (int i = 0; i < 8; i++) begin
            wr(vecs[i].waddr, vecs[i].wdata);
            rd(vecs[i].raddr, r);
            chk($sformatf("vec%0d", i), r, vecs[i].exp_rd);
        end

        // PWM duty
        wr(3'd1, 32'h0);
        wr(3'd3, 32'h0);
        wr(3'd2, 32'd64);
        wr(3'd0, 32'h001);
        cycles(2);
        ones = 0;
        for (int i = 0; i < 256; i++) begin
            @(posedge clk); #1;
            ones += int'(out_port[0]);
        end
        chk("pwm_64", ones, 64);

        wr(3'd2, 32'd0);
        cycles(2);
        ones = 0;
        for (int i = 0; i < 256; i++) begin
            @(posedge clk); #1;
            ones += int'(out_port[0]);
        end
        chk("pwm_0", ones, 0);

        wr(3'd2, 32'd255);
        cycles(2);
        ones = 0;
        for (int i = 0; i < 256; i++) begin
            @(posedge clk); #1;
            ones += int'(out_port[0]);
        end
        chk("pwm_255", ones, 256);

        // Blink, period 10: high for 10 output cycles, then low for 10
        wr(3'd1, 32'h001);
        wr(3'd0, 32'h003);
        wr(3'd3, 32'd10);
        for (int j = 1; j <= 40; j++) begin
            @(posedge clk); #1;
            chk($sformatf("blink10_b0_%0d", j), {31'h0, out_port[0]},
                {31'h0, (((j - 1) / 10) % 2) == 0});
            chk($sformatf("blink10_b1_%0d", j), {31'h0, out_port[1]}, 32'h1);
        end

        // Period rewrite while bit 0 is low
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk); #1;
            if (out_port[0] == 1'b0) found = 1'b1;
        end
        chk("blink_low_wait", {31'h0, found}, 32'h1);
        wr(3'd3, 32'd4);
        for (int j = 1; j <= 16; j++) begin
            @(posedge clk); #1;
            chk($sformatf("blink4_b0_%0d", j), {31'h0, out_port[0]},
                {31'h0, (((j - 1) / 4) % 2) == 0});
        end

        // Period zero: steady on
        wr(3'd3, 32'd0);
        cycles(1);
        ones = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            ones += int'(out_port[0]);
        end
        chk("period0_steady", ones, 30);

        // SET/CLR aliases
`ifdef PLATFORM_LED_PWM_SETCLR_EN
        exp_set   = 32'h0F3;
        exp_clr   = 32'h0C3;
        exp_alias = 32'h0C3;
`else
        exp_set   = 32'h0F0;
        exp_clr   = 32'h0F0;
        exp_alias = 32'h000;
`endif
        wr(3'd0, 32'h0F0);
        wr(3'd4, 32'h003);
        rd(3'd0, r); chk("set_data", r, exp_set);
        wr(3'd5, 32'h030);
        rd(3'd0, r); chk("clr_data", r, exp_clr);
        rd(3'd4, r); chk("alias_set_rd", r, exp_alias);
        rd(3'd5, r); chk("alias_clr_rd", r, exp_alias);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
